display_scan: RTL and testbench
===============================

DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 Parameter PRESCALE, default 50000, clock cycles per digit slot (1 kHz slot rate at 50 MHz); legal range 4..2^20.
REQ-002 Parameter DEADTIME, default 500, clock cycles of all-anodes-off at the start of each slot; legal range 1..PRESCALE-2.
REQ-003 Parameter BLINK_SLOTS, default 250, slots per blink half-period; legal range 1..2^12.
REQ-004 clock  in  1  single system clock; all state changes on its rising edge.
REQ-005 Reset  in  1  asynchronous, active-low reset.
REQ-006 digit0..digit3  in  7 each  segment codes {g..a} from the seven-segment encoders; 1 = segment lit; digit0 is the rightmost digit (minute units).
REQ-007 blank_mask  in  4  bit i = 1 forces digit i dark.
REQ-008 blink_mask  in  4  bit i = 1 makes digit i blink (adjust-mode indication).
REQ-009 alarm  in  1  alarm-active flag; drives the blinking decimal point.
REQ-010 an  out  4  anode enables, active-low; an[i] = 0 selects digit i.
REQ-011 seg  out  7  cathodes {g..a}, active-low.
REQ-012 dp  out  1  decimal point, active-low.
REQ-013 blink_phase  out  1  current blink phase; 1 = blinking digits dark.

Function
REQ-014 Prescaler counts 0..PRESCALE-1 and wraps; tick is high in the cycle where count = PRESCALE-1; the prescaler runs freely and never stalls.
REQ-015 FSM has two states, DEAD and SHOW; on the edge ending a tick cycle it enters DEAD from either state and increments the 2-bit digit pointer (3 wraps to 0).
REQ-016 DEAD lasts exactly DEADTIME cycles: an = 4'b1111, seg = 7'b1111111, dp = 1; then SHOW.
REQ-017 On the DEAD->SHOW edge, digit[ptr], blank_mask[ptr], blink_mask[ptr], alarm and blink_phase are captured into a slot register; outputs hold these values for the rest of the slot, and input changes mid-slot have no visible effect.
REQ-018 In SHOW, an = ~(4'b0001 << ptr), and an, seg and dp are all registered outputs.
REQ-019 In SHOW, seg = 7'b1111111 if captured blank, or if captured blink and captured phase = 1; otherwise seg = ~captured digit.
REQ-020 In SHOW, dp = 0 only when ptr = 2 (hour/minute separator), captured alarm = 1 and captured phase = 0; otherwise dp = 1.
REQ-021 Blink counter counts ticks 0..BLINK_SLOTS-1; on the tick where it equals BLINK_SLOTS-1 it wraps and blink_phase toggles.
REQ-022 Each digit is lit for PRESCALE-DEADTIME cycles per slot, and a full scan takes 4*PRESCALE cycles.
REQ-023 At most one an bit is 0 in any cycle; an and seg never change in the same cycle as a digit switch without passing through DEAD.
REQ-024 Simultaneous blank and blink on a digit: blank wins.

Reset
REQ-025 Reset low forces, asynchronously: an = 4'b1111, seg = 7'b1111111, dp = 1, blink_phase = 0, prescaler = 0, blink counter = 0, ptr = 0, state = DEAD with a full DEADTIME count, slot register cleared.
REQ-026 After Reset deasserts, the first SHOW displays digit0 after DEADTIME cycles.
REQ-027 Reset asserted mid-slot or mid-DEAD takes effect immediately, with no partial-slot output.

Verification (PRESCALE=8, DEADTIME=2, BLINK_SLOTS=4)
REQ-028 Release reset, digit0..3 = 7'h3F,7'h06,7'h5B,7'h4F, masks 0 -> cycles 0-1 an=1111; cycles 2-7 an=1110, seg=7'h40; cycles 8-9 an=1111; cycles 10-15 an=1101, seg=7'h79; after digit3, pointer wraps to digit0.
REQ-029 blank_mask=4'b0100 -> in slot 2, an=1011 and seg=7'h7F; other digits unaffected.
REQ-030 blink_mask=4'b0011 -> blink_phase toggles every 32 cycles; digits 0-1 are dark when blink_phase=1 and show normally when it is 0; digits 2-3 are always lit.
REQ-031 alarm=1 -> dp=0 only during SHOW of slot 2 while phase=0; alarm=0 -> dp=1 always.
REQ-032 Change digit0 from 7'h3F to 7'h06 mid-SHOW of slot 0 -> seg stays 7'h40 until the slot ends; the next slot-0 SHOW gives seg=7'h79.
REQ-033 Assert Reset during SHOW of slot 2 -> same cycle an=1111, seg=7'h7F; after release, the sequence restarts exactly as in REQ-028; assertion checks at most one an bit low throughout.

Source files
------------

// File: rtl/display_scan.sv
// -----------------------------------------------------------------------------
// display_scan
//
// Time-multiplexed driver for a four-digit common-anode seven-segment display.
// A free-running prescaler cuts time into digit slots. Each slot opens with a
// dead band where every anode is off, so ghosting from the previous digit
// cannot appear. The slot's digit, masks, alarm flag and blink phase are then
// latched into a slot register and held until the slot ends. A slower blink
// counter, advanced once per slot, provides the blink phase for adjust-mode
// digits and for the alarm decimal point.
//
// Parameters
//   PRESCALE     clock cycles per digit slot (4 .. 2^20)
//   DEADTIME     all-anodes-off cycles at the start of each slot (1 .. PRESCALE-2)
//   BLINK_SLOTS  slots per blink half-period (1 .. 2^12)
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   digit0..3    segment codes {g..a}, 1 = lit; digit0 is the rightmost digit
//   blank_mask   bit i forces digit i dark
//   blink_mask   bit i makes digit i blink
//   alarm        alarm active; blinks the hour/minute separator point
//   an           anode enables, active-low, an[i] = 0 selects digit i
//   seg          cathodes {g..a}, active-low
//   dp           decimal point, active-low
//   blink_phase  current blink phase, 1 = blinking digits dark
// -----------------------------------------------------------------------------
module display_scan #(
  parameter int unsigned PRESCALE    = 50000,
  parameter int unsigned DEADTIME    = 500,
  parameter int unsigned BLINK_SLOTS = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] digit0,
  input  logic [6:0] digit1,
  input  logic [6:0] digit2,
  input  logic [6:0] digit3,
  input  logic [3:0] blank_mask,
  input  logic [3:0] blink_mask,
  input  logic       alarm,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       blink_phase
);

  localparam int unsigned PW = $clog2(PRESCALE);
  localparam int unsigned BW = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;

  localparam logic [PW-1:0] PresMax  = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] DeadLoad = PW'(DEADTIME - 1);
  localparam logic [BW-1:0] BlinkMax = BW'(BLINK_SLOTS - 1);

  localparam logic [3:0] AnOff  = 4'b1111;
  localparam logic [6:0] SegOff = 7'b1111111;

  typedef enum logic {StDead, StShow} state_e;

  // Timebase
  logic [PW-1:0] presc_q;
  logic          tick;
  logic [BW-1:0] blink_cnt_q;
  logic          blink_phase_q;

  // Scan FSM
  state_e        state_q;
  logic [PW-1:0] dead_cnt_q;
  logic [1:0]    ptr_q;

  // Slot register: everything the current slot displays
  logic [6:0]    slot_digit_q;
  logic          slot_blank_q;
  logic          slot_blink_q;
  logic          slot_alarm_q;
  logic          slot_phase_q;

  // Registered pins
  logic [3:0]    an_q;
  logic [6:0]    seg_q;
  logic          dp_q;

  // Inputs belonging to the digit the pointer currently addresses
  logic [6:0]    cur_digit;
  logic          cur_blank;
  logic          cur_blink;

  assign tick = (presc_q == PresMax);

  always_comb begin
    cur_digit = digit0;
    unique case (ptr_q)
      2'd0: cur_digit = digit0;
      2'd1: cur_digit = digit1;
      2'd2: cur_digit = digit2;
      2'd3: cur_digit = digit3;
      default: cur_digit = digit0;
    endcase
  end

  assign cur_blank = blank_mask[ptr_q];
  assign cur_blink = blink_mask[ptr_q];

  // Cathode pattern for a slot; blanking overrides blinking.
  function automatic logic [6:0] seg_drive(input logic [6:0] code, input logic blank,
                                           input logic blink, input logic phase);
    if (blank || (blink && phase)) begin
      return SegOff;
    end
    return ~code;
  endfunction

  // The point only lights as the hour/minute separator (slot 2).
  function automatic logic dp_drive(input logic [1:0] ptr, input logic alm, input logic phase);
    return !((ptr == 2'd2) && alm && !phase);
  endfunction

  // Free-running prescaler and blink timebase; neither ever stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q       <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      if (tick) begin
        presc_q <= '0;
        if (blink_cnt_q == BlinkMax) begin
          blink_cnt_q   <= '0;
          blink_phase_q <= ~blink_phase_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + 1'b1;
        end
      end else begin
        presc_q <= presc_q + 1'b1;
      end
    end
  end

  // Scan FSM with slot capture and registered pin drivers. A tick always
  // forces DEAD, so the anodes go dark before the pointer moves on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StDead;
      dead_cnt_q   <= DeadLoad;
      ptr_q        <= 2'd0;
      slot_digit_q <= '0;
      slot_blank_q <= 1'b0;
      slot_blink_q <= 1'b0;
      slot_alarm_q <= 1'b0;
      slot_phase_q <= 1'b0;
      an_q         <= AnOff;
      seg_q        <= SegOff;
      dp_q         <= 1'b1;
    end else if (tick) begin
      state_q    <= StDead;
      dead_cnt_q <= DeadLoad;
      ptr_q      <= ptr_q + 2'd1;
      an_q       <= AnOff;
      seg_q      <= SegOff;
      dp_q       <= 1'b1;
    end else begin
      unique case (state_q)
        StDead: begin
          if (dead_cnt_q == '0) begin
            state_q      <= StShow;
            slot_digit_q <= cur_digit;
            slot_blank_q <= cur_blank;
            slot_blink_q <= cur_blink;
            slot_alarm_q <= alarm;
            slot_phase_q <= blink_phase_q;
            an_q         <= ~(4'b0001 << ptr_q);
            seg_q        <= seg_drive(cur_digit, cur_blank, cur_blink, blink_phase_q);
            dp_q         <= dp_drive(ptr_q, alarm, blink_phase_q);
          end else begin
            dead_cnt_q <= dead_cnt_q - 1'b1;
          end
        end
        StShow: begin
          // Refreshed only from the slot register, so mid-slot input changes are invisible.
          an_q  <= ~(4'b0001 << ptr_q);
          seg_q <= seg_drive(slot_digit_q, slot_blank_q, slot_blink_q, slot_phase_q);
          dp_q  <= dp_drive(ptr_q, slot_alarm_q, slot_phase_q);
        end
        default: begin
          state_q    <= StDead;
          dead_cnt_q <= DeadLoad;
        end
      endcase
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign blink_phase = blink_phase_q;

endmodule

// File: tb/tb_display_scan.sv
// -----------------------------------------------------------------------------
// tb_display_scan
//
// Bench for display_scan with PRESCALE=8, DEADTIME=2, BLINK_SLOTS=4. Expected
// outputs come from a cycle-index model: slot = t/8, position = t%8, pointer =
// slot%4, blink phase = (t/32)%2, with the slot's inputs taken as whatever was
// applied in the last dead cycle of that slot.
// -----------------------------------------------------------------------------
module tb_display_scan;

  localparam int P = 8;
  localparam int D = 2;
  localparam int B = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] digit0, digit1, digit2, digit3;
  logic [3:0] blank_mask, blink_mask;
  logic       alarm;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       blink_phase;

  display_scan #(
    .PRESCALE   (P),
    .DEADTIME   (D),
    .BLINK_SLOTS(B)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digit0     (digit0),
    .digit1     (digit1),
    .digit2     (digit2),
    .digit3     (digit3),
    .blank_mask (blank_mask),
    .blink_mask (blink_mask),
    .alarm      (alarm),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .blink_phase(blink_phase)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  int t = 0;

  // Values the tests want applied at the start of the next cycle
  logic [6:0] nxt_dig[4];
  logic [3:0] nxt_blank, nxt_blink;
  logic       nxt_alarm;

  // Model state
  logic [6:0] cap_digit;
  logic       cap_blank, cap_blink, cap_alarm;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp, exp_ph;

  task automatic set_canonical();
    nxt_dig[0] = 7'h3F; nxt_dig[1] = 7'h06; nxt_dig[2] = 7'h5B; nxt_dig[3] = 7'h4F;
    nxt_blank = 4'b0000; nxt_blink = 4'b0000; nxt_alarm = 1'b0;
  endtask

  // Apply pending inputs for cycle t, update the model, then wait to the sample point.
  task automatic apply(input bit rnd);
    int pos, s, p;
    bit sp;
    if (rnd) begin
      for (int i = 0; i < 4; i++) nxt_dig[i] = 7'($urandom);
      nxt_blank = 4'($urandom) & 4'($urandom);
      nxt_blink = 4'($urandom);
      nxt_alarm = 1'($urandom);
    end
    digit0 = nxt_dig[0]; digit1 = nxt_dig[1]; digit2 = nxt_dig[2]; digit3 = nxt_dig[3];
    blank_mask = nxt_blank; blink_mask = nxt_blink; alarm = nxt_alarm;
    pos = t % P;
    s   = t / P;
    p   = s % 4;
    sp  = ((s / B) % 2) == 1;
    if (pos == D - 1) begin
      cap_digit = nxt_dig[p];
      cap_blank = nxt_blank[p];
      cap_blink = nxt_blink[p];
      cap_alarm = nxt_alarm;
    end
    exp_ph = ((t / (P * B)) % 2) == 1;
    if (pos < D) begin
      exp_an = 4'b1111; exp_seg = 7'h7F; exp_dp = 1'b1;
    end else begin
      exp_an = 4'b1111;
      exp_an[p] = 1'b0;
      exp_seg = (cap_blank || (cap_blink && sp)) ? 7'h7F : ~cap_digit;
      exp_dp = !(p == 2 && cap_alarm && !sp);
    end
    @(negedge clk);
  endtask

  task automatic step(input bit rnd);
    @(posedge clk);
    #1;
    t++;
    apply(rnd);
  endtask

  // Holds reset across a few edges and releases it just after a rising edge (cycle 0).
  task automatic restart();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    t = 0;
    apply(1'b0);
  endtask

  task automatic test_reset();
    set_canonical();
    nxt_blank = 4'b1010; nxt_alarm = 1'b1;
    digit0 = nxt_dig[0]; digit1 = nxt_dig[1]; digit2 = nxt_dig[2]; digit3 = nxt_dig[3];
    blank_mask = nxt_blank; blink_mask = nxt_blink; alarm = nxt_alarm;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks += 4;
    if (an !== 4'b1111) begin n_fails++; $display("FAIL reset_an got %b want 1111", an); end
    if (seg !== 7'h7F) begin n_fails++; $display("FAIL reset_seg got %h want 7f", seg); end
    if (dp !== 1'b1) begin n_fails++; $display("FAIL reset_dp got %b want 1", dp); end
    if (blink_phase !== 1'b0) begin
      n_fails++; $display("FAIL reset_phase got %b want 0", blink_phase);
    end
  endtask

  task automatic test_scan();
    set_canonical();
    restart();
    for (int c = 0; c < 72; c++) begin
      if (c > 0) step(1'b0);
      n_checks += 5;
      if (an !== exp_an) begin n_fails++; $display("FAIL scan_an t=%0d got %b want %b", t, an, exp_an); end
      if (seg !== exp_seg) begin n_fails++; $display("FAIL scan_seg t=%0d got %h want %h", t, seg, exp_seg); end
      if (dp !== exp_dp) begin n_fails++; $display("FAIL scan_dp t=%0d got %b want %b", t, dp, exp_dp); end
      if (blink_phase !== exp_ph) begin
        n_fails++; $display("FAIL scan_phase t=%0d got %b want %b", t, blink_phase, exp_ph);
      end
      if ($countones(~an) > 1) begin n_fails++; $display("FAIL scan_onehot t=%0d an=%b", t, an); end
      if (t == 2 || t == 10 || t == 34) begin
        n_checks += 2;
        if (an !== ((t == 10) ? 4'b1101 : 4'b1110)) begin
          n_fails++; $display("FAIL scan_spot_an t=%0d got %b", t, an);
        end
        if (seg !== ((t == 10) ? 7'h79 : 7'h40)) begin
          n_fails++; $display("FAIL scan_spot_seg t=%0d got %h", t, seg);
        end
      end
    end
  endtask

  task automatic test_blank();
    set_canonical();
    nxt_blank = 4'b0100;
    restart();
    for (int c = 0; c < 64; c++) begin
      if (c > 0) step(1'b0);
      n_checks += 4;
      if (an !== exp_an) begin n_fails++; $display("FAIL blank_an t=%0d got %b want %b", t, an, exp_an); end
      if (seg !== exp_seg) begin n_fails++; $display("FAIL blank_seg t=%0d got %h want %h", t, seg, exp_seg); end
      if (dp !== exp_dp) begin n_fails++; $display("FAIL blank_dp t=%0d got %b want %b", t, dp, exp_dp); end
      if ($countones(~an) > 1) begin n_fails++; $display("FAIL blank_onehot t=%0d an=%b", t, an); end
      if (t == 20) begin
        n_checks += 2;
        if (an !== 4'b1011) begin n_fails++; $display("FAIL blank_spot_an got %b want 1011", an); end
        if (seg !== 7'h7F) begin n_fails++; $display("FAIL blank_spot_seg got %h want 7f", seg); end
      end
    end
  endtask

  task automatic test_blink();
    set_canonical();
    nxt_blink = 4'b0011;
    restart();
    for (int c = 0; c < 136; c++) begin
      if (c > 0) step(1'b0);
      n_checks += 4;
      if (an !== exp_an) begin n_fails++; $display("FAIL blink_an t=%0d got %b want %b", t, an, exp_an); end
      if (seg !== exp_seg) begin n_fails++; $display("FAIL blink_seg t=%0d got %h want %h", t, seg, exp_seg); end
      if (blink_phase !== exp_ph) begin
        n_fails++; $display("FAIL blink_phase t=%0d got %b want %b", t, blink_phase, exp_ph);
      end
      if ($countones(~an) > 1) begin n_fails++; $display("FAIL blink_onehot t=%0d an=%b", t, an); end
      if (t == 34 || t == 42 || t == 50) begin
        n_checks++;
        if (seg !== ((t == 50) ? 7'h24 : 7'h7F)) begin
          n_fails++; $display("FAIL blink_spot_seg t=%0d got %h", t, seg);
        end
      end
    end
  endtask

  task automatic test_alarm();
    set_canonical();
    nxt_alarm = 1'b1;
    restart();
    for (int c = 0; c < 200; c++) begin
      if (c > 0) step(1'b0);
      if (c == 128) nxt_alarm = 1'b0;
      n_checks += 3;
      if (dp !== exp_dp) begin n_fails++; $display("FAIL alarm_dp t=%0d got %b want %b", t, dp, exp_dp); end
      if (an !== exp_an) begin n_fails++; $display("FAIL alarm_an t=%0d got %b want %b", t, an, exp_an); end
      if (seg !== exp_seg) begin n_fails++; $display("FAIL alarm_seg t=%0d got %h want %h", t, seg, exp_seg); end
      if (t == 18 || t == 50 || t == 82 || t == 150) begin
        n_checks++;
        if (dp !== ((t == 18 || t == 82) ? 1'b0 : 1'b1)) begin
          n_fails++; $display("FAIL alarm_spot_dp t=%0d got %b", t, dp);
        end
      end
    end
  endtask

  task automatic test_midslot_change();
    set_canonical();
    restart();
    for (int c = 0; c < 40; c++) begin
      if (c > 0) step(1'b0);
      if (t == 4) nxt_dig[0] = 7'h06;
      n_checks += 2;
      if (seg !== exp_seg) begin n_fails++; $display("FAIL mid_seg t=%0d got %h want %h", t, seg, exp_seg); end
      if (an !== exp_an) begin n_fails++; $display("FAIL mid_an t=%0d got %b want %b", t, an, exp_an); end
      if (t >= 5 && t <= 7) begin
        n_checks++;
        if (seg !== 7'h40) begin n_fails++; $display("FAIL mid_hold t=%0d got %h want 40", t, seg); end
      end
      if (t == 34) begin
        n_checks++;
        if (seg !== 7'h79) begin n_fails++; $display("FAIL mid_next t=%0d got %h want 79", t, seg); end
      end
    end
  endtask

  task automatic test_random();
    restart();
    for (int c = 0; c < 400; c++) begin
      step(1'b1);
      n_checks += 5;
      if (an !== exp_an) begin n_fails++; $display("FAIL rand_an t=%0d got %b want %b", t, an, exp_an); end
      if (seg !== exp_seg) begin n_fails++; $display("FAIL rand_seg t=%0d got %h want %h", t, seg, exp_seg); end
      if (dp !== exp_dp) begin n_fails++; $display("FAIL rand_dp t=%0d got %b want %b", t, dp, exp_dp); end
      if (blink_phase !== exp_ph) begin
        n_fails++; $display("FAIL rand_phase t=%0d got %b want %b", t, blink_phase, exp_ph);
      end
      if ($countones(~an) > 1) begin n_fails++; $display("FAIL rand_onehot t=%0d an=%b", t, an); end
    end
  endtask

  task automatic test_reset_midslot();
    set_canonical();
    nxt_alarm = 1'b1;
    restart();
    while (t < 20) step(1'b0);
    n_checks++;
    if (an !== 4'b1011) begin n_fails++; $display("FAIL rmid_pre_an got %b want 1011", an); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks += 4;
    if (an !== 4'b1111) begin n_fails++; $display("FAIL rmid_an got %b want 1111", an); end
    if (seg !== 7'h7F) begin n_fails++; $display("FAIL rmid_seg got %h want 7f", seg); end
    if (dp !== 1'b1) begin n_fails++; $display("FAIL rmid_dp got %b want 1", dp); end
    if (blink_phase !== 1'b0) begin n_fails++; $display("FAIL rmid_phase got %b want 0", blink_phase); end
    set_canonical();
    restart();
    for (int c = 0; c < 40; c++) begin
      if (c > 0) step(1'b0);
      n_checks += 3;
      if (an !== exp_an) begin n_fails++; $display("FAIL rmid_re_an t=%0d got %b want %b", t, an, exp_an); end
      if (seg !== exp_seg) begin n_fails++; $display("FAIL rmid_re_seg t=%0d got %h want %h", t, seg, exp_seg); end
      if ($countones(~an) > 1) begin n_fails++; $display("FAIL rmid_onehot t=%0d an=%b", t, an); end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blank();
    test_blink();
    test_alarm();
    test_midslot_change();
    test_random();
    test_reset_midslot();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
